// File: rtl/ram_block_reader.sv
// Burst reader for an async SRAM: reads len consecutive words from base_addr, strobing each out.
// Optional RAM_READ_CHECK_EN compares each word against seed + index and counts mismatches.
module ram_block_reader #(
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 16,
    parameter int LEN_W     = 5,
    parameter int OE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [LEN_W-1:0]  rd_index,
    output logic              err_flag,
    output logic [LEN_W-1:0]  err_count,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic              ram_en_n
);

    localparam int CNT_W = (OE_CYCLES > 1) ? $clog2(OE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [LEN_W-1:0]  rd_index_q, rd_index_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_valid_q, rd_valid_d;
    logic              oe_n_q, oe_n_d;
    logic              en_n_q, en_n_d;
    logic              err_flag_q, err_flag_d;
    logic [LEN_W-1:0]  err_count_q, err_count_d;

`ifdef RAM_READ_CHECK_EN
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [DATA_W-1:0] expect_w;
`else
    logic              unused_seed;
    assign unused_seed = ^seed;
`endif

    assign ram_data = 'z;
    assign ram_we_n = 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        remain_d    = remain_q;
        addr_d      = addr_q;
        rd_data_d   = rd_data_q;
        rd_index_d  = rd_index_q;
        err_flag_d  = err_flag_q;
        err_count_d = err_count_q;
`ifdef RAM_READ_CHECK_EN
        seed_d      = seed_q;
        expect_w    = seed_q + DATA_W'(rd_index_q);
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_flag_d  = 1'b0;
                    err_count_d = '0;
                    if (len != '0) begin
                        state_d    = S_SETUP;
                        addr_d     = base_addr;
                        remain_d   = len;
                        rd_index_d = '0;
`ifdef RAM_READ_CHECK_EN
                        seed_d     = seed;
`endif
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
                cnt_d   = '0;
            end
            S_STROBE: begin
                if (cnt_q == CNT_W'(OE_CYCLES - 1)) begin
                    rd_data_d = ram_data;
                    state_d   = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                addr_d     = addr_q + 1'b1;
                rd_index_d = rd_index_q + 1'b1;
                remain_d   = remain_q - 1'b1;
                state_d    = (remain_q > LEN_W'(1)) ? S_SETUP : S_DONE;
`ifdef RAM_READ_CHECK_EN
                if (rd_data_q != expect_w) begin
                    err_flag_d = 1'b1;
                    if (err_count_q != '1)
                        err_count_d = err_count_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes and bus controls are registered copies decoded from the next state.
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        rd_valid_d = (state_d == S_SAMPLE);
        oe_n_d     = (state_d != S_STROBE);
        en_n_d     = !((state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_SAMPLE));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            remain_q    <= '0;
            addr_q      <= '0;
            rd_data_q   <= '0;
            rd_index_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            oe_n_q      <= 1'b1;
            en_n_q      <= 1'b1;
            err_flag_q  <= 1'b0;
            err_count_q <= '0;
`ifdef RAM_READ_CHECK_EN
            seed_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            remain_q    <= remain_d;
            addr_q      <= addr_d;
            rd_data_q   <= rd_data_d;
            rd_index_q  <= rd_index_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_valid_q  <= rd_valid_d;
            oe_n_q      <= oe_n_d;
            en_n_q      <= en_n_d;
            err_flag_q  <= err_flag_d;
            err_count_q <= err_count_d;
`ifdef RAM_READ_CHECK_EN
            seed_q      <= seed_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_index  = rd_index_q;
    assign err_flag  = err_flag_q;
    assign err_count = err_count_q;
    assign ram_addr  = addr_q;
    assign ram_oe_n  = oe_n_q;
    assign ram_en_n  = en_n_q;

endmodule

// File: tb/tb_ram_block_reader.sv
// Directed bench for ram_block_reader with an SRAM array model and an expected-word scoreboard.
// Error expectations follow RAM_READ_CHECK_EN the same way the design does.
module tb_ram_block_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [17:0] base_addr;
    logic [4:0]  len;
    logic [15:0] seed;
    logic        busy, done, rd_valid, err_flag;
    logic [15:0] rd_data;
    logic [4:0]  rd_index, err_count;
    logic [17:0] ram_addr;
    wire  [15:0] ram_data;
    logic        ram_oe_n, ram_we_n, ram_en_n;

    logic [15:0] mem [0:262143];

    typedef struct {
        logic [15:0] data;
        logic [17:0] addr;
        logic [4:0]  idx;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    assign ram_data = ram_oe_n ? 16'hzzzz : mem[ram_addr];

    always #5 clk = ~clk;

    ram_block_reader #(.ADDR_W(18), .DATA_W(16), .LEN_W(5), .OE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len), .seed(seed),
        .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid), .rd_index(rd_index),
        .err_flag(err_flag), .err_count(err_count), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .ram_en_n(ram_en_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!rd_valid && cyc < 40);
    endtask

    task automatic push_burst(input logic [17:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.addr = b + 18'(i);
            e.data = mem[e.addr];
            e.idx  = 5'(i);
            sb.push_back(e);
        end
    endtask

    task automatic issue(input logic [17:0] b, input logic [4:0] l, input logic [15:0] s);
        base_addr = b;
        len       = l;
        seed      = s;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Pops one expected word and compares it against the next rd_valid strobe.
    task automatic pop_word(input bit check_gap);
        int   cyc;
        exp_t e;
        wait_valid(cyc);
        check("valid_seen", rd_valid, 1);
        e = sb.pop_front();
        if (check_gap) check("word_gap", cyc, 4);
        check("rd_data", rd_data, e.data);
        check("rd_index", rd_index, e.idx);
        check("ram_addr", ram_addr, e.addr);
        check("oe_n_sample", ram_oe_n, 1);
        check("en_n_sample", ram_en_n, 0);
    endtask

    task automatic finish_burst();
        tick();
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 1);
        tick();
        check("done_clear", done, 0);
        check("busy_clear", busy, 0);
        check("en_n_idle", ram_en_n, 1);
    endtask

    initial begin
        int done_seen;
        logic [4:0] exp_err;
        rst = 1'b0; start = 1'b0; base_addr = '0; len = '0; seed = '0;

        // Reset values
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_index", rd_index, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_oe_n", ram_oe_n, 1);
        check("rst_en_n", ram_en_n, 1);
        check("rst_err_flag", err_flag, 0);
        check("rst_err_count", err_count, 0);
        check("rst_we_n", ram_we_n, 1);
        rst = 1'b1;
        tick();
        check("idle_busy", busy, 0);
        check("idle_en_n", ram_en_n, 1);

        // Ten-word burst from 0x10
        for (int i = 0; i < 10; i++) mem[18'h10 + 18'(i)] = 16'h1234 + 16'(i);
        push_burst(18'h10, 10);
        issue(18'h10, 5'd10, 16'h1234);
        check("busy_start", busy, 1);
        for (int i = 0; i < 10; i++) pop_word(i != 0);
        finish_burst();
        check("err_flag_clean", err_flag, 0);
        check("ram_addr_hold", ram_addr, 18'h1A);
        tick();
        check("ram_addr_hold2", ram_addr, 18'h1A);

        // Zero-length request
        issue(18'h40, 5'd0, 16'h0);
        check("len0_done", done, 1);
        check("len0_en_n", ram_en_n, 1);
        check("len0_oe_n", ram_oe_n, 1);
        tick();
        check("len0_done_once", done, 0);
        check("len0_busy", busy, 0);
        check("len0_oe_n2", ram_oe_n, 1);

        // Address wrap
        mem[18'h3FFFE] = 16'hA000; mem[18'h3FFFF] = 16'hA001;
        mem[18'h00000] = 16'hA002; mem[18'h00001] = 16'hA003;
        push_burst(18'h3FFFE, 4);
        issue(18'h3FFFE, 5'd4, 16'hA000);
        for (int i = 0; i < 4; i++) pop_word(i != 0);
        finish_burst();

        // Start while busy, then reset mid-burst
        for (int i = 0; i < 8; i++) mem[18'h100 + 18'(i)] = 16'h5A00 + 16'(i);
        mem[18'h3000] = 16'hDEAD;
        push_burst(18'h100, 8);
        issue(18'h100, 5'd8, 16'h5A00);
        for (int i = 0; i < 3; i++) pop_word(i != 0);
        issue(18'h3000, 5'd3, 16'h0);
        check("ignored_start_busy", busy, 1);
        pop_word(1'b0);
        rst = 1'b0;
        tick();
        check("abort_busy", busy, 0);
        check("abort_oe_n", ram_oe_n, 1);
        check("abort_en_n", ram_en_n, 1);
        check("abort_done", done, 0);
        check("abort_valid", rd_valid, 0);
        rst = 1'b1;
        sb.delete();
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || rd_valid) done_seen++;
        end
        check("abort_no_done", done_seen, 0);

        // Data compare: one bad word at index 3
        mem[18'h200] = 16'h0005; mem[18'h201] = 16'h0006; mem[18'h202] = 16'h0007;
        mem[18'h203] = 16'hFFFF; mem[18'h204] = 16'h0009;
`ifdef RAM_READ_CHECK_EN
        exp_err = 5'd1;
`else
        exp_err = 5'd0;
`endif
        push_burst(18'h200, 5);
        issue(18'h200, 5'd5, 16'h0005);
        for (int i = 0; i < 4; i++) begin
            pop_word(i != 0);
            if (i == 2) check("err_before_bad", err_flag, 0);
        end
        tick();
        check("err_flag_bad", err_flag, 32'(exp_err != 0));
        check("err_count_bad", err_count, exp_err);
        begin
            int   cyc;
            exp_t e;
            wait_valid(cyc);
            check("valid_seen", rd_valid, 1);
            e = sb.pop_front();
            check("gap_after_err", cyc, 3);
            check("rd_data", rd_data, e.data);
            check("rd_index", rd_index, e.idx);
        end
        finish_burst();
        check("err_count_end", err_count, exp_err);
        check("err_flag_sticky", err_flag, 32'(exp_err != 0));
        push_burst(18'h10, 1);
        issue(18'h10, 5'd1, 16'h1234);
        check("err_flag_cleared", err_flag, 0);
        check("err_count_cleared", err_count, 0);
        pop_word(1'b0);
        finish_burst();
        check("err_flag_good", err_flag, 0);
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
